// File: rtl/matrix_mul_pkg.sv
// ---------------------------------------------------------------------------
// matrix_mul_pkg
// Shared definitions for the matrix-multiply datapath. The operand-fetch
// control unit and the result block writer both import this package.
//
// Contents:
//   DATA_W     default width of one matrix element / RAM word
//   ADDR_W     default RAM address width
//   RAM_DEPTH  number of words in the result RAM
//   wr_state_t state encoding of the result block writer FSM
// ---------------------------------------------------------------------------
package matrix_mul_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 9;
    localparam int RAM_DEPTH = 1 << ADDR_W;

    // IDLE waits for start, CALC resolves the block address, W11..W22 issue
    // the four element writes, FIN emits the done pulse.
    typedef enum logic [2:0] {
        IDLE,
        CALC,
        W11,
        W12,
        W21,
        W22,
        FIN
    } wr_state_t;

endpackage

// File: rtl/result_block_writer_addr_calc.sv
// ---------------------------------------------------------------------------
// rb_addr_calc
// Combinational address and geometry check for one 2x2 result block.
// Computes r0 = c_base + 2*blk_row*mat_dim + 2*blk_col at full width and
// flags any geometry that would leave the matrix or run past the RAM end.
//
// Ports:
//   c_base_i    RAM address of C[0][0]
//   mat_dim_i   matrix dimension N
//   blk_row_i   block row index
//   blk_col_i   block column index
//   r0_o        low addr_w bits of r0 (exact whenever bad_geom_o is low)
//   bad_geom_o  high when the request must be rejected
// ---------------------------------------------------------------------------
module rb_addr_calc
    import matrix_mul_pkg::*;
#(
    parameter int addr_w = ADDR_W
) (
    input  logic [addr_w-1:0] c_base_i,
    input  logic [addr_w-1:0] mat_dim_i,
    input  logic [addr_w-2:0] blk_row_i,
    input  logic [addr_w-2:0] blk_col_i,
    output logic [addr_w-1:0] r0_o,
    output logic              bad_geom_o
);

    // Wide enough for c_base + 2*row*N + 2*col + N + 1 without overflow.
    localparam int CW = 2 * addr_w + 1;

    localparam logic [CW-1:0] ONE_W    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ADDR_MAX = {{(CW-addr_w){1'b0}}, {addr_w{1'b1}}};

    logic [CW-1:0] base_w;
    logic [CW-1:0] dim_w;
    logic [CW-1:0] row2_w;
    logic [CW-1:0] col2_w;
    logic [CW-1:0] r0_w;
    logic [CW-1:0] last_w;

    // All arithmetic is done unsigned at CW bits so the range check sees the
    // true value; only after the check passes is r0 narrowed to addr_w bits.
    // The last element written is r0+N+1, so that is what must fit.
    always_comb begin
        base_w = CW'(c_base_i);
        dim_w  = CW'(mat_dim_i);
        row2_w = CW'(blk_row_i) << 1;
        col2_w = CW'(blk_col_i) << 1;
        r0_w   = base_w + (row2_w * dim_w) + col2_w;
        last_w = r0_w + dim_w + ONE_W;

        bad_geom_o = (mat_dim_i == '0)
                   | mat_dim_i[0]
                   | ((col2_w + ONE_W) >= dim_w)
                   | ((row2_w + ONE_W) >= dim_w)
                   | (last_w > ADDR_MAX);

        r0_o = r0_w[addr_w-1:0];
    end

endmodule

// File: rtl/result_block_writer.sv
// ---------------------------------------------------------------------------
// result_block_writer
// Stores one finished 2x2 result block into the result RAM as four
// single-word writes in row-major order: (r0,c_11), (r0+1,c_12),
// (r0+N,c_21), (r0+N+1,c_22). Bad geometry ends the request with err
// instead of writing anything.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request, sampled only in IDLE
//   c_base            RAM address of C[0][0]
//   mat_dim           matrix dimension N
//   blk_row, blk_col  block indices
//   c_11..c_22        block elements, captured on acceptance
//   ram_we            registered RAM write enable
//   ram_addr          registered RAM write address
//   ram_w_data        registered RAM write data
//   busy              high while a request is in flight
//   done              one-cycle pulse at the end of each request
//   err               set with done on a rejected request, held until next start
// ---------------------------------------------------------------------------
module result_block_writer
    import matrix_mul_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int addr_w = ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [addr_w-1:0] c_base,
    input  logic [addr_w-1:0] mat_dim,
    input  logic [addr_w-2:0] blk_row,
    input  logic [addr_w-2:0] blk_col,
    input  logic [data_w-1:0] c_11,
    input  logic [data_w-1:0] c_12,
    input  logic [data_w-1:0] c_21,
    input  logic [data_w-1:0] c_22,
    output logic              ram_we,
    output logic [addr_w-1:0] ram_addr,
    output logic [data_w-1:0] ram_w_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [addr_w-1:0] ONE_A = {{(addr_w-1){1'b0}}, 1'b1};

    wr_state_t         state_q;

    logic [data_w-1:0] c11_q, c12_q, c21_q, c22_q;
    logic [addr_w-1:0] c_base_q;
    logic [addr_w-1:0] mat_dim_q;
    logic [addr_w-2:0] blk_row_q;
    logic [addr_w-2:0] blk_col_q;

    logic [addr_w-1:0] r0_q;
    logic [addr_w-1:0] r0_d;
    logic              bad_q;
    logic              bad_geom_d;

    logic [addr_w-1:0] addr_d;
    logic [data_w-1:0] data_d;

    logic              ram_we_q;
    logic [addr_w-1:0] ram_addr_q;
    logic [data_w-1:0] ram_w_data_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    // The address calculator only ever sees latched operands, so input
    // changes after acceptance cannot disturb the block in flight.
    rb_addr_calc #(
        .addr_w (addr_w)
    ) u_addr_calc (
        .c_base_i   (c_base_q),
        .mat_dim_i  (mat_dim_q),
        .blk_row_i  (blk_row_q),
        .blk_col_i  (blk_col_q),
        .r0_o       (r0_d),
        .bad_geom_o (bad_geom_d)
    );

    // Address/data of the write issued from the current write state. r0+N+1
    // was range-checked at full width, so these addr_w-bit sums cannot wrap.
    always_comb begin
        addr_d = r0_q;
        data_d = c11_q;
        case (state_q)
            W12: begin
                addr_d = r0_q + ONE_A;
                data_d = c12_q;
            end
            W21: begin
                addr_d = r0_q + mat_dim_q;
                data_d = c21_q;
            end
            W22: begin
                addr_d = r0_q + mat_dim_q + ONE_A;
                data_d = c22_q;
            end
            default: begin
                addr_d = r0_q;
                data_d = c11_q;
            end
        endcase
    end

    // Main FSM with registered outputs. ram_we and done default low each
    // cycle so they can only pulse from the states that set them; ram_addr
    // and ram_w_data simply hold between writes. busy rises on the CALC
    // cycle and falls on the FIN cycle, together with done. A rejected
    // request goes CALC -> FIN and never touches the write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            c11_q        <= '0;
            c12_q        <= '0;
            c21_q        <= '0;
            c22_q        <= '0;
            c_base_q     <= '0;
            mat_dim_q    <= '0;
            blk_row_q    <= '0;
            blk_col_q    <= '0;
            r0_q         <= '0;
            bad_q        <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_w_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            ram_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        c11_q     <= c_11;
                        c12_q     <= c_12;
                        c21_q     <= c_21;
                        c22_q     <= c_22;
                        c_base_q  <= c_base;
                        mat_dim_q <= mat_dim;
                        blk_row_q <= blk_row;
                        blk_col_q <= blk_col;
                        err_q     <= 1'b0;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    busy_q  <= 1'b1;
                    r0_q    <= r0_d;
                    bad_q   <= bad_geom_d;
                    state_q <= bad_geom_d ? FIN : W11;
                end
                W11, W12, W21, W22: begin
                    ram_we_q     <= 1'b1;
                    ram_addr_q   <= addr_d;
                    ram_w_data_q <= data_d;
                    case (state_q)
                        W11:     state_q <= W12;
                        W12:     state_q <= W21;
                        W21:     state_q <= W22;
                        default: state_q <= FIN;
                    endcase
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= bad_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_w_data = ram_w_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_result_block_writer.sv
// ---------------------------------------------------------------------------
// tb_result_block_writer
// Directed bench for result_block_writer. Each request is launched on a
// falling edge; the outputs are then sampled on the next 16 falling edges
// (trace index k = outputs registered at rising edge T+k) and compared
// against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_result_block_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  c_base;
    logic [8:0]  mat_dim;
    logic [7:0]  blk_row;
    logic [7:0]  blk_col;
    logic [31:0] c_11, c_12, c_21, c_22;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [31:0] ram_w_data;
    logic        busy;
    logic        done;
    logic        err;

    int total;
    int bad;

    logic        tWe   [0:15];
    logic [8:0]  tAddr [0:15];
    logic [31:0] tData [0:15];
    logic        tBusy [0:15];
    logic        tDone [0:15];
    logic        tErr  [0:15];

    result_block_writer #(
        .data_w (32),
        .addr_w (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .c_base     (c_base),
        .mat_dim    (mat_dim),
        .blk_row    (blk_row),
        .blk_col    (blk_col),
        .c_11       (c_11),
        .c_12       (c_12),
        .c_21       (c_21),
        .c_22       (c_22),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_w_data (ram_w_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A write strobe outside a busy window is always wrong.
    always @(negedge clk) begin
        if (!rst && ram_we === 1'b1)
            checkOutput("we_outside_busy", busy, 1);
    end

    // Launch one request and record 16 cycles of outputs. start is dropped
    // after sample holdK; mutate scrambles c_11/blk_col right after edge T.
    task automatic applyStimulus(input int base, input int dim, input int row, input int col,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d,
                                 input int holdK, input bit mutate);
        c_base  = base[8:0];
        mat_dim = dim[8:0];
        blk_row = row[7:0];
        blk_col = col[7:0];
        c_11 = a;
        c_12 = b;
        c_21 = c;
        c_22 = d;
        start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            tWe[k]   = ram_we;
            tAddr[k] = ram_addr;
            tData[k] = ram_w_data;
            tBusy[k] = busy;
            tDone[k] = done;
            tErr[k]  = err;
            if (k == 0 && mutate) begin
                c_11    = 32'hDEAD_BEEF;
                blk_col = 8'd0;
            end
            if (k == holdK)
                start = 1'b0;
        end
    endtask

    // Expected trace of an accepted, valid request starting at trace offset off.
    task automatic expectNormal(input string nm, input int off,
                                input int a0, input int a1, input int a2, input int a3,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
        int ea [0:3];
        logic [31:0] ed [0:3];
        ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
        ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
        checkOutput({nm, "_busy_k1"}, tBusy[off+1], 1);
        for (int k = 0; k <= 6; k++)
            checkOutput($sformatf("%s_we_k%0d", nm, k), tWe[off+k], (k >= 2 && k <= 5) ? 1 : 0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s_addr%0d", nm, k), tAddr[off+2+k], ea[k]);
            checkOutput($sformatf("%s_data%0d", nm, k), tData[off+2+k], ed[k]);
        end
        checkOutput({nm, "_done_k5"}, tDone[off+5], 0);
        checkOutput({nm, "_done_k6"}, tDone[off+6], 1);
        checkOutput({nm, "_busy_k6"}, tBusy[off+6], 0);
        checkOutput({nm, "_err_k6"},  tErr[off+6],  0);
    endtask

    // Expected trace of a rejected request: done+err at T+2, no writes.
    task automatic expectError(input string nm);
        for (int k = 0; k < 6; k++)
            checkOutput($sformatf("%s_we_k%0d", nm, k), tWe[k], 0);
        checkOutput({nm, "_busy_k1"}, tBusy[1], 1);
        checkOutput({nm, "_done_k1"}, tDone[1], 0);
        checkOutput({nm, "_done_k2"}, tDone[2], 1);
        checkOutput({nm, "_err_k2"},  tErr[2],  1);
        checkOutput({nm, "_busy_k2"}, tBusy[2], 0);
        checkOutput({nm, "_done_k3"}, tDone[3], 0);
        checkOutput({nm, "_err_k5"},  tErr[5],  1);
    endtask

    initial begin
        int  nWrites;
        int  nDone;
        bit  sawDone;

        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        start   = 1'b0;
        c_base  = '0;
        mat_dim = '0;
        blk_row = '0;
        blk_col = '0;
        c_11 = '0; c_12 = '0; c_21 = '0; c_22 = '0;

        // Reset values
        #1;
        checkOutput("rst_we",   ram_we,     0);
        checkOutput("rst_addr", ram_addr,   0);
        checkOutput("rst_data", ram_w_data, 0);
        checkOutput("rst_busy", busy,       0);
        checkOutput("rst_done", done,       0);
        checkOutput("rst_err",  err,        0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] case 1: N=4 base=32 block (1,1)");
        applyStimulus(32, 4, 1, 1, 1, 2, 3, 4, 0, 0);
        expectNormal("t1", 0, 42, 43, 46, 47, 1, 2, 3, 4);

        $display("[TB] case 2: block runs past RAM end");
        applyStimulus(500, 8, 1, 0, 9, 9, 9, 9, 0, 0);
        expectError("t2");

        $display("[TB] case 3: odd and zero N, then valid request");
        applyStimulus(0, 3, 0, 0, 9, 9, 9, 9, 0, 0);
        expectError("t3odd");
        applyStimulus(0, 0, 0, 0, 9, 9, 9, 9, 0, 0);
        expectError("t3zero");
        applyStimulus(0, 2, 0, 0, 5, 6, 7, 8, 0, 0);
        checkOutput("t3_err_clear", tErr[0], 0);
        expectNormal("t3ok", 0, 0, 1, 2, 3, 5, 6, 7, 8);

        $display("[TB] boundaries: last word 511, one past, column out of range");
        applyStimulus(508, 2, 0, 0, 32'hA, 32'hB, 32'hC, 32'hD, 0, 0);
        expectNormal("tEdge", 0, 508, 509, 510, 511, 32'hA, 32'hB, 32'hC, 32'hD);
        applyStimulus(509, 2, 0, 0, 9, 9, 9, 9, 0, 0);
        expectError("tPast");
        applyStimulus(0, 4, 0, 2, 9, 9, 9, 9, 0, 0);
        expectError("tCol");
        applyStimulus(0, 4, 2, 0, 9, 9, 9, 9, 0, 0);
        expectError("tRow");

        $display("[TB] case 4: start held high");
        applyStimulus(32, 4, 1, 1, 1, 2, 3, 4, 13, 0);
        expectNormal("t4a", 0, 42, 43, 46, 47, 1, 2, 3, 4);
        expectNormal("t4b", 7, 42, 43, 46, 47, 1, 2, 3, 4);
        nWrites = 0;
        nDone   = 0;
        for (int k = 0; k < 16; k++) begin
            if (tWe[k])   nWrites++;
            if (tDone[k]) nDone++;
        end
        checkOutput("t4_writes", nWrites, 8);
        checkOutput("t4_dones",  nDone,   2);

        $display("[TB] case 5: inputs change after acceptance");
        applyStimulus(32, 4, 1, 1, 1, 2, 3, 4, 0, 1);
        expectNormal("t5", 0, 42, 43, 46, 47, 1, 2, 3, 4);

        $display("[TB] case 6: reset mid-write");
        c_base  = 9'd32;
        mat_dim = 9'd4;
        blk_row = 8'd1;
        blk_col = 8'd1;
        c_11 = 1; c_12 = 2; c_21 = 3; c_22 = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_we_before", ram_we, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_we",   ram_we,     0);
        checkOutput("t6_addr", ram_addr,   0);
        checkOutput("t6_data", ram_w_data, 0);
        checkOutput("t6_busy", busy,       0);
        checkOutput("t6_done", done,       0);
        checkOutput("t6_err",  err,        0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || ram_we) sawDone = 1'b1;
        end
        checkOutput("t6_quiet_after", sawDone, 0);
        applyStimulus(32, 4, 1, 1, 1, 2, 3, 4, 0, 0);
        expectNormal("t6again", 0, 42, 43, 46, 47, 1, 2, 3, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
